sha256_msg_sched: RTL

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

---
 rtl/sha256_msg_sched.sv | 82 ++++++++
 1 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator: expands one 512-bit block into ROUNDS words W[t].
// Define MSG_SCHED_STALL_EN to let w_ready_i stall the schedule; otherwise one word per RUN cycle.
module sha256_msg_sched #(
   parameter int ROUNDS = 64
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [511:0] block_i,
   output logic         ready_o,
   output logic         w_valid_o,
   input  logic         w_ready_i,
   output logic [31:0]  w_o,
   output logic [5:0]   round_o,
   output logic         done_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

   state_t      state_q, state_d;
   logic [31:0] wbuf_q [16];
   logic [5:0]  round_q;
   logic        xfer;
   logic [31:0] new_word;

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

`ifdef MSG_SCHED_STALL_EN
   assign xfer = (state_q == RUN) && w_ready_i;
`else
   logic unused_w_ready;
   assign unused_w_ready = w_ready_i;
   assign xfer = (state_q == RUN);
`endif

   // wbuf_q[0] is always the word being offered, so the recurrence taps sit at fixed slots
   assign new_word = sigma1(wbuf_q[14]) + wbuf_q[9] + sigma0(wbuf_q[1]) + wbuf_q[0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = RUN;
         RUN:     if (xfer && (round_q == LAST_ROUND)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         round_q <= '0;
         for (int i = 0; i < 16; i++) wbuf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && start_i) begin
            round_q <= '0;
            for (int i = 0; i < 16; i++) wbuf_q[i] <= block_i[511 - 32*i -: 32];
         end else if (xfer && (round_q != LAST_ROUND)) begin
            // the final word is not shifted out, so round_o never wraps
            round_q <= round_q + 6'd1;
            for (int i = 0; i < 15; i++) wbuf_q[i] <= wbuf_q[i+1];
            wbuf_q[15] <= new_word;
         end
      end
   end

   assign ready_o   = (state_q == IDLE);
   assign w_valid_o = (state_q == RUN);
   assign done_o    = (state_q == DONE);
   assign w_o       = wbuf_q[0];
   assign round_o   = round_q;

endmodule
